// File: rtl/sipo.sv
// UART receive front end: 16x oversampled serial-to-parallel capture of one
// 11-bit frame, handed to the deframe unit with a one-cycle def_en strobe.
module sipo (
    input  logic        baud_clk,
    input  logic        rstn,
    input  logic        rx,
    output logic        busy,
    output logic [10:0] data_out,
    output logic        def_en
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;
    logic        r_rxMeta;
    logic        r_rxs;
    logic        r_rxsD;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic [3:0]  r_bitn;
    logic [3:0]  w_bitnNext;
    logic [9:0]  r_shreg;
    logic [9:0]  w_shregNext;
    logic [10:0] r_dataOut;
    logic [10:0] w_dataOutNext;
    logic        r_defEn;
    logic        w_defEnNext;

    // Synchronizer and edge-detect history idle high so reset never looks like a start edge.
    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            r_rxMeta <= 1'b1;
            r_rxs    <= 1'b1;
            r_rxsD   <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxs    <= r_rxMeta;
            r_rxsD   <= r_rxs;
        end
    end

    always_ff @(posedge baud_clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_bitn    <= 4'd0;
            r_shreg   <= 10'd0;
            r_dataOut <= 11'h000;
            r_defEn   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_bitn    <= w_bitnNext;
            r_shreg   <= w_shregNext;
            r_dataOut <= w_dataOutNext;
            r_defEn   <= w_defEnNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_bitnNext    = r_bitn;
        w_shregNext   = r_shreg;
        w_dataOutNext = r_dataOut;
        w_defEnNext   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Only a high-to-low transition starts a frame, so a held break is ignored.
                if (r_rxsD && !r_rxs) begin
                    w_stateNext = S_START;
                    w_cntNext   = 4'd0;
                end
            end

            S_START: begin
                w_cntNext = r_cnt + 4'd1;
                if (r_cnt == 4'd7) begin
                    if (r_rxs) begin
                        w_stateNext = S_IDLE;
                    end else begin
                        w_stateNext = S_DATA;
                        w_cntNext   = 4'd0;
                        w_bitnNext  = 4'd1;
                    end
                end
            end

            S_DATA: begin
                w_cntNext = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_cntNext   = 4'd0;
                    w_shregNext = {r_rxs, r_shreg[9:1]};
                    w_bitnNext  = r_bitn + 4'd1;
                    // Stop-bit sample: shreg[9:1] now holds {parity, d7..d0}.
                    if (r_bitn == 4'd10) begin
                        w_dataOutNext = {r_rxs, r_shreg[9:1], 1'b0};
                        w_defEnNext   = 1'b1;
                        w_bitnNext    = 4'd0;
                        w_stateNext   = S_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != S_IDLE);
    assign data_out = r_dataOut;
    assign def_en   = r_defEn;

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_sipo;

    logic        baud_clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic        busy;
    logic [10:0] data_out;
    logic        def_en;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int busyCycles  = 0;
    int defCyc[$];
    logic [10:0] defWord[$];
    logic [10:0] expWord;

    sipo dut (
        .baud_clk (baud_clk),
        .rstn     (rstn),
        .rx       (rx),
        .busy     (busy),
        .data_out (data_out),
        .def_en   (def_en)
    );

    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc <= cyc + 1;

    // Record every strobe cycle and the frame seen with it, sampled mid-period.
    always @(negedge baud_clk) begin
        if (def_en) begin
            defCyc.push_back(cyc);
            defWord.push_back(data_out);
        end
        if (busy) busyCycles++;
    end

    function automatic logic [10:0] frameWord(input logic [7:0] data, input logic par, input logic stop);
        return {stop, par, data, 1'b0};
    endfunction

    task automatic clearMonitor();
        defCyc.delete();
        defWord.delete();
        busyCycles = 0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge baud_clk);
    endtask

    // Drive bits LSB first, 16 cycles each; startCyc is the cycle rx takes bit 0.
    task automatic sendBits(input logic [10:0] bits, input int nbits, output int startCyc);
        startCyc = 0;
        for (int i = 0; i < nbits; i++) begin
            @(posedge baud_clk);
            #1;
            rx = bits[i];
            if (i == 0) startCyc = cyc;
            repeat (15) @(posedge baud_clk);
        end
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic par, input logic stop, output int startCyc);
        sendBits(frameWord(data, par, stop), 11, startCyc);
    endtask

    // Synchronizer skew adds 2-3 cycles ahead of the 168-cycle frame latency.
    task automatic checkLatency(input string name, input int startCyc, input int strobeCyc);
        int lat;
        lat = strobeCyc - startCyc;
        vectors++;
        if (lat < 170 || lat > 171) begin
            miscompares++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected 170..171", name, lat);
        end
    endtask

    task automatic checkFrames(input string name, input int expCount);
        vectors++;
        if (defCyc.size() != expCount) begin
            miscompares++;
            $display("[TB] FAIL %s strobe count: got %0d, expected %0d", name, defCyc.size(), expCount);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx   = 1'b1;
        #3;
        for (int i = 0; i < 6; i++) begin
            rx = $urandom_range(0, 1);
            @(negedge baud_clk);
            vectors++;
            if (busy !== 1'b0 || def_en !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset busy/def_en: got %b/%b, expected 0/0", busy, def_en);
            end
            vectors++;
            if (data_out !== 11'h000) begin
                miscompares++;
                $display("[TB] FAIL reset data_out: got %h, expected 000", data_out);
            end
        end
        rx = 1'b1;
        idleCycles(3);
        #1;
        rstn = 1'b1;
        idleCycles(10);
        expWord = 11'h000;
        vectors++;
        if (busy !== 1'b0 || data_out !== expWord) begin
            miscompares++;
            $display("[TB] FAIL post-reset idle: got busy=%b data_out=%h, expected 0/%h", busy, data_out, expWord);
        end
    endtask

    task automatic test_single_frame();
        int s;
        clearMonitor();
        sendFrame(8'h55, 1'b1, 1'b1, s);
        idleCycles(20);
        expWord = 11'h6AA;
        checkFrames("single", 1);
        if (defCyc.size() >= 1) begin
            vectors++;
            if (defWord[0] !== expWord) begin
                miscompares++;
                $display("[TB] FAIL single data_out: got %h, expected %h", defWord[0], expWord);
            end
            checkLatency("single", s, defCyc[0]);
        end
        vectors++;
        if (busyCycles != 168) begin
            miscompares++;
            $display("[TB] FAIL single busy width: got %0d, expected 168", busyCycles);
        end
    endtask

    task automatic test_false_start();
        clearMonitor();
        @(posedge baud_clk);
        #1;
        rx = 1'b0;
        idleCycles(4);
        #1;
        rx = 1'b1;
        idleCycles(40);
        vectors++;
        if (busyCycles < 7 || busyCycles > 9) begin
            miscompares++;
            $display("[TB] FAIL false-start busy width: got %0d, expected 7..9", busyCycles);
        end
        checkFrames("false-start", 0);
        vectors++;
        if (data_out !== expWord || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL false-start hold: got data_out=%h busy=%b, expected %h/0", data_out, busy, expWord);
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        int s2;
        clearMonitor();
        sendFrame(8'h55, 1'b1, 1'b1, s1);
        sendFrame(8'hA3, 1'b0, 1'b1, s2);
        idleCycles(20);
        checkFrames("b2b", 2);
        if (defCyc.size() == 2) begin
            vectors++;
            if (defWord[0] !== 11'h6AA || defWord[1] !== 11'h546) begin
                miscompares++;
                $display("[TB] FAIL b2b data_out: got %h,%h expected 6aa,546", defWord[0], defWord[1]);
            end
            vectors++;
            if (defCyc[1] - defCyc[0] != s2 - s1) begin
                miscompares++;
                $display("[TB] FAIL b2b spacing: got %0d, expected %0d", defCyc[1] - defCyc[0], s2 - s1);
            end
            checkLatency("b2b first", s1, defCyc[0]);
        end
        expWord = 11'h546;
    endtask

    task automatic test_bad_stop_break();
        int s;
        clearMonitor();
        sendFrame(8'hFF, 1'b0, 1'b0, s);
        idleCycles(200);
        checkFrames("break", 1);
        if (defCyc.size() >= 1) begin
            vectors++;
            if (defWord[0] !== frameWord(8'hFF, 1'b0, 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL break data_out: got %h, expected %h", defWord[0], frameWord(8'hFF, 1'b0, 1'b0));
            end
        end
        vectors++;
        if (busy !== 1'b0 || busyCycles != 168) begin
            miscompares++;
            $display("[TB] FAIL break retrigger: got busy=%b busyCycles=%0d, expected 0/168", busy, busyCycles);
        end
        #1;
        rx = 1'b1;
        idleCycles(20);
        sendFrame(8'h3C, 1'b0, 1'b1, s);
        idleCycles(20);
        expWord = frameWord(8'h3C, 1'b0, 1'b1);
        checkFrames("after break", 2);
        if (defCyc.size() == 2) begin
            vectors++;
            if (defWord[1] !== expWord) begin
                miscompares++;
                $display("[TB] FAIL after-break data_out: got %h, expected %h", defWord[1], expWord);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s;
        logic [10:0] w;
        clearMonitor();
        w = frameWord(8'h96, 1'b0, 1'b1);
        sendBits(w, 5, s);
        @(posedge baud_clk);
        #1;
        rx = w[5];
        idleCycles(7);
        #3;
        rstn = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || def_en !== 1'b0 || data_out !== 11'h000) begin
            miscompares++;
            $display("[TB] FAIL mid-frame reset: got busy=%b def_en=%b data_out=%h, expected 0/0/000", busy, def_en, data_out);
        end
        rx = 1'b1;
        idleCycles(3);
        #1;
        rstn = 1'b1;
        idleCycles(200);
        checkFrames("mid-reset discard", 0);
        sendFrame(8'h96, 1'b0, 1'b1, s);
        idleCycles(20);
        expWord = w;
        checkFrames("after reset", 1);
        if (defCyc.size() >= 1) begin
            vectors++;
            if (defWord[0] !== expWord) begin
                miscompares++;
                $display("[TB] FAIL after-reset data_out: got %h, expected %h", defWord[0], expWord);
            end
            checkLatency("after reset", s, defCyc[0]);
        end
    endtask

    task automatic test_random_frames();
        int          s;
        int          gap;
        logic [7:0]  data;
        logic        par;
        int          expStart[$];
        logic [10:0] expQ[$];
        clearMonitor();
        for (int k = 0; k < 10; k++) begin
            data = 8'($urandom_range(0, 255));
            par  = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 12);
            idleCycles(gap);
            sendFrame(data, par, 1'b1, s);
            expStart.push_back(s);
            expQ.push_back(frameWord(data, par, 1'b1));
        end
        idleCycles(20);
        checkFrames("random", 10);
        if (defCyc.size() == 10) begin
            for (int k = 0; k < 10; k++) begin
                vectors++;
                if (defWord[k] !== expQ[k]) begin
                    miscompares++;
                    $display("[TB] FAIL random frame %0d data_out: got %h, expected %h", k, defWord[k], expQ[k]);
                end
                checkLatency("random", expStart[k], defCyc[k]);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        rx   = 1'b1;
        test_reset();
        test_single_frame();
        test_false_start();
        test_back_to_back();
        test_bad_stop_break();
        test_reset_mid_frame();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sipo.md
# sipo

Serial-in/parallel-out receive front end of the full-duplex UART core. It oversamples the serial line `rx` at 16× the bit rate on `baud_clk`, which is 153.6 kHz for 9600 baud. It captures one complete 11-bit frame: start, 8 data bits LSB-first, parity, stop. It then presents the frame on `data_out` with a one-cycle `def_en` strobe to the downstream deframe unit, which performs the parity, stop and start checks.

## Interface
- No parameters. Oversampling is fixed at 16 and the frame length at 11 bits.
- `baud_clk` in 1: 16× oversampling clock; all logic on its rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial input; idles high; asynchronous to `baud_clk`.
- `busy` out 1: high while a frame is being received.
- `data_out` out 11: last completed frame, laid out as {stop, parity, d7..d0, start}, with `data_out[0]` = start bit.
- `def_en` out 1: one-cycle pulse when `data_out` has been updated with a new frame.

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1. The synchronized value `rxs` and its previous value `rxs_d` (also reset to 1) feed the FSM.
- A 4-bit oversample counter `cnt` and a bit counter `bitn` (0..10) drive the sampling.
- A 10-bit shift register holds the bits sampled after the start bit.
- **IDLE**: `busy`=0.
  - A falling edge (`rxs_d`=1, `rxs`=0) moves to START with `cnt`=0.
  - `rx` held low without a preceding high does not start a frame, so a break cannot retrigger.
- **START**: `busy`=1; `cnt` increments each cycle.
  - At `cnt`==7 (mid start bit), `rxs` is sampled.
  - If `rxs`=1 the start is false: return to IDLE, no `def_en`, `data_out` unchanged.
  - If `rxs`=0 the start is valid: go to DATA with `cnt`=0 and `bitn`=1.
- **DATA**: `busy`=1; `cnt` increments each cycle.
  - At `cnt`==15, `rxs` is sampled. The shift register shifts right with `rxs` entering the MSB, `cnt` goes to 0, and `bitn` increments.
  - The sample taken at `bitn`==10 is the stop bit. On that same edge:
    - `data_out` is loaded with {`rxs`, shreg[9:1]… } so that the result is {stop, parity, d7..d0, 0}.
    - `def_en` is set to 1 and `busy` to 0.
    - The FSM returns to IDLE.
- The stop bit value is not checked here. A frame with stop = 0 is still delivered.
- `def_en` clears on the next edge, so it is exactly one `baud_clk` cycle wide.
- `data_out` holds its value until the next completed frame. It never changes during reception.
- **Reset** (asynchronous, at any time, including mid-frame):
  - FSM goes to IDLE; all counters and the shift register clear.
  - `busy`=0, `def_en`=0, `data_out`=11'h000, synchronizer flops = 1.
  - A partial frame is discarded.

## Timing
- Let E0 be the edge on which IDLE detects the falling edge of `rxs`. This is 2–3 cycles after `rx` falls, because of the synchronizer.
- `busy` rises at E0.
- The start bit is sampled at E0+8.
- Data bits 0..7 are sampled at E0+24, E0+40, …, E0+136.
- Parity is sampled at E0+152.
- Stop is sampled at E0+168. `data_out` updates, `def_en` rises and `busy` falls at E0+168; `def_en` falls at E0+169.
- Frame latency is 168 cycles from detection to `def_en`.
- Back-to-back frames are supported:
  - IDLE is re-entered at mid-stop bit, 8 cycles before the next start edge can occur.
  - A start edge arriving in the cycle `def_en` is high is accepted.
- Every sample point falls at mid-bit (±1 cycle of synchronizer skew) for a `rx` aligned to a 16-cycle bit period.

## Test plan
- **Reset values:** assert `rstn`=0 while `rx`=1 → `busy`=0, `def_en`=0, `data_out`=11'h000; these hold while in reset even if `rx` toggles.
- **Single frame:** release reset, drive `rx`=0 (start), then 1,0,1,0,1,0,1,0 (d0..d7), 1 (parity), 1 (stop), 16 cycles per bit → exactly one `def_en` pulse of 1 cycle, with `data_out`=11'h6AA and `busy` high for 168 cycles.
- **False start:** drive `rx` low for 4 cycles, then high → `busy` pulses high for about 8 cycles, no `def_en`, `data_out` unchanged.
- **Back-to-back frames:** send 0x55 then 0xA3 (parity 1 and 0, stop 1) with no idle gap → two `def_en` pulses 176 cycles apart, with `data_out`=11'h6AA, then {1,0,8'hA3,0}=11'h546.
- **Bad stop / break:** send data 0xFF with stop=0, then hold `rx` low → one `def_en` with `data_out[10]`=0; no further frames until `rx` returns high and falls again.
- **Reset mid-frame:** pulse `rstn` low at about bit 4 of a frame → `busy`=0 immediately and no `def_en` for that frame; the next full frame is received correctly.
